// File: rtl/fadder_pipe.sv
// Pipelined WIDTH-bit add/subtract: one CHUNK-bit slice per stage, carry registered between stages.
// Valid/ready handshake with a single global advance enable; one result per cycle at full rate.
module fadder_pipe #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int STAGES = WIDTH / CHUNK;

    // Returns {carry into slice MSB, carry out of slice, slice sum}.
    function automatic logic [CHUNK+1:0] slice_add(
        input logic [CHUNK-1:0] x,
        input logic [CHUNK-1:0] y,
        input logic             c
    );
        logic [CHUNK-1:0] g;
        logic [CHUNK-1:0] p;
        logic [CHUNK:0]   c_v;
        g      = x & y;
        p      = x ^ y;
        c_v    = '0;
        c_v[0] = c;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            c_v[i+1] = g[i] | (p[i] & c_v[i]);
        end
        return {c_v[CHUNK-1], c_v[CHUNK], p ^ c_v[CHUNK-1:0]};
    endfunction

    logic [WIDTH-1:0] r_a   [STAGES];
    logic [WIDTH-1:0] r_b   [STAGES];
    logic [WIDTH-1:0] r_sum [STAGES];
    logic             r_c   [STAGES];
    logic             r_v   [STAGES];
    logic             r_ovf;

    logic [WIDTH-1:0] w_src_a   [STAGES];
    logic [WIDTH-1:0] w_src_b   [STAGES];
    logic [WIDTH-1:0] w_src_s   [STAGES];
    logic             w_src_c   [STAGES];
    logic             w_src_v   [STAGES];
    logic [CHUNK+1:0] w_res     [STAGES];
    logic [WIDTH-1:0] w_next_sum[STAGES];
    logic             w_en;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_c0;

    assign w_b_eff   = sub ? ~b : b;
    assign w_c0      = sub ^ cin;
    assign w_en      = !r_v[STAGES-1] || out_ready;
    assign in_ready  = w_en;
    assign out_valid = r_v[STAGES-1];
    assign sum       = r_sum[STAGES-1];
    assign cout      = r_c[STAGES-1];
    assign ovf       = r_ovf;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign w_src_a[k] = a;
            assign w_src_b[k] = w_b_eff;
            assign w_src_s[k] = '0;
            assign w_src_c[k] = w_c0;
            assign w_src_v[k] = in_valid;
        end else begin : g_rest
            assign w_src_a[k] = r_a[k-1];
            assign w_src_b[k] = r_b[k-1];
            assign w_src_s[k] = r_sum[k-1];
            assign w_src_c[k] = r_c[k-1];
            assign w_src_v[k] = r_v[k-1];
        end
        assign w_res[k] = slice_add(w_src_a[k][k*CHUNK +: CHUNK],
                                    w_src_b[k][k*CHUNK +: CHUNK],
                                    w_src_c[k]);
    end

    always_comb begin
        for (int unsigned k = 0; k < STAGES; k++) begin
            w_next_sum[k] = w_src_s[k];
            w_next_sum[k][k*CHUNK +: CHUNK] = w_res[k][CHUNK-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_sum[k] <= '0;
                r_c[k]   <= 1'b0;
                r_v[k]   <= 1'b0;
            end
            r_ovf <= 1'b0;
        end else if (w_en) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                r_a[k]   <= w_src_a[k];
                r_b[k]   <= w_src_b[k];
                r_sum[k] <= w_next_sum[k];
                r_c[k]   <= w_res[k][CHUNK];
                r_v[k]   <= w_src_v[k];
            end
            // Overflow only exists at the MSB slice, so it is formed in the final stage.
            r_ovf <= w_res[STAGES-1][CHUNK+1] ^ w_res[STAGES-1][CHUNK];
        end
    end
endmodule

// File: tb/tb_fadder_pipe.sv
// Self-checking bench for fadder_pipe: directed vector table, scoreboarded streaming,
// random backpressure, and reset during a stalled, full pipe.
module tb_fadder_pipe;
    localparam int W   = 16;
    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    always #5 clk = ~clk;

    fadder_pipe #(.WIDTH(W), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } vec_t;

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    int          sent = 0;
    int          rcvd = 0;
    logic        hold_pending = 1'b0;
    logic [W+1:0] held;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic mcin, input logic msub);
        exp_t         r;
        logic [W-1:0] be;
        logic         c0;
        logic [W:0]   full;
        be   = msub ? ~mb : mb;
        c0   = msub ? ~mcin : mcin;
        full = {1'b0, ma} + {1'b0, be} + {{W{1'b0}}, c0};
        r.s  = full[W-1:0];
        r.c  = full[W];
        r.o  = (ma[W-1] == be[W-1]) && (full[W-1] != ma[W-1]);
        return r;
    endfunction

    // One clock: drive, settle, check/score, then advance to the next falling edge.
    task automatic step(input logic iv, input logic ordy, input logic [W-1:0] ia,
                        input logic [W-1:0] ib, input logic icin, input logic isub);
        exp_t e;
        in_valid  = iv;
        out_ready = ordy;
        a = ia; b = ib; cin = icin; sub = isub;
        #1;
        chk("in_ready_en", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
        if (hold_pending) begin
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_data", {14'd0, sum, cout, ovf}, {14'd0, held});
        end
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("no_extra_out", 32'd1, 32'd0);
            end else if (out_ready) begin
                e = q.pop_front();
                chk("stream_result", {14'd0, sum, cout, ovf}, {14'd0, e.s, e.c, e.o});
                rcvd++;
            end
        end
        hold_pending = out_valid && !out_ready;
        held = {sum, cout, ovf};
        if (iv && in_ready) begin
            q.push_back(model(ia, ib, icin, isub));
            sent++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_single(input vec_t v, input string name);
        int lat;
        in_valid = 1'b1; out_ready = 1'b1;
        a = v.a; b = v.b; cin = v.cin; sub = v.sub;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        chk({name, "_latency"}, lat, LAT);
        chk({name, "_sum"}, {16'd0, sum}, {16'd0, v.s});
        chk({name, "_cout"}, {31'd0, cout}, {31'd0, v.c});
        chk({name, "_ovf"}, {31'd0, ovf}, {31'd0, v.o});
        @(posedge clk);
        @(negedge clk);
        chk({name, "_single_out"}, {31'd0, out_valid}, 32'd0);
    endtask

    vec_t vecs[10];

    initial begin
        int   cyc;
        int   idle_bad;
        vec_t v;

        vecs[0] = '{16'd5,      16'd7,      1'b0, 1'b0, 16'd12,     1'b0, 1'b0};
        vecs[1] = '{16'd10,     16'd3,      1'b0, 1'b1, 16'd7,      1'b1, 1'b0};
        vecs[2] = '{16'hFFFF,   16'd1,      1'b0, 1'b0, 16'h0000,   1'b1, 1'b0};
        vecs[3] = '{16'h7FFF,   16'd1,      1'b0, 1'b0, 16'h8000,   1'b0, 1'b1};
        vecs[4] = '{16'd0,      16'd1,      1'b0, 1'b1, 16'hFFFF,   1'b0, 1'b0};
        vecs[5] = '{16'h1234,   16'h1234,   1'b0, 1'b1, 16'h0000,   1'b1, 1'b0};
        vecs[6] = '{16'h8000,   16'd1,      1'b0, 1'b1, 16'h7FFF,   1'b1, 1'b1};
        vecs[7] = '{16'd10,     16'd3,      1'b1, 1'b1, 16'd6,      1'b1, 1'b0};
        vecs[8] = '{16'hFFFF,   16'd0,      1'b1, 1'b0, 16'h0000,   1'b1, 1'b0};
        vecs[9] = '{16'h8000,   16'h8000,   1'b0, 1'b0, 16'h0000,   1'b1, 1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        @(negedge clk);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum", {16'd0, sum}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        idle_bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) idle_bad++;
        end
        chk("idle_no_valid", idle_bad, 0);

        for (int i = 0; i < 10; i++) begin
            run_single(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-to-back streaming: 100 inputs, exactly 100 outputs within LAT extra cycles.
        for (int i = 0; i < 100 + LAT; i++) begin
            step(i < 100, 1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        end
        chk("stream_count", rcvd, 100);
        chk("stream_drained", q.size(), 0);

        // Random backpressure and bubbles over 1000 operations.
        sent = 0; rcvd = 0;
        cyc = 0;
        while (sent < 1000 && cyc < 20000) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
            cyc++;
        end
        cyc = 0;
        while (q.size() != 0 && cyc < 200) begin
            step(1'b0, $urandom_range(0, 2) != 0, '0, '0, 1'b0, 1'b0);
            cyc++;
        end
        chk("bp_sent", sent, 1000);
        chk("bp_received", rcvd, 1000);
        chk("bp_drained", q.size(), 0);

        // Fill the pipe, stall the output, then reset with an input also offered.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, W'(16'h1000 + i), W'(16'h0100), 1'b0, 1'b0);
        end
        chk("fill_stalled", {31'd0, out_valid}, 32'd1);
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        a = 16'hAAAA; b = 16'h5555;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_data", {14'd0, sum, cout, ovf}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        q.delete();
        hold_pending = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, '0, '0, 1'b0, 1'b0);
        end
        v = '{16'd1, 16'd2, 1'b0, 1'b0, 16'd3, 1'b0, 1'b0};
        run_single(v, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
